cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares the single-port memory bus between instruction fetch (IF) and data access (MEM) in the 5-stage core.
- Grants one transfer at a time; data requests win over fetch.
- Holds each requester's ready low until its transfer completes. The pipeline stalls on that ready.
- Handles a killed fetch (branch, trap or interrupt flush) and a bus timeout, which is reported as an access fault.

Parameters:
- ADDR_WIDTH, 32, bus/requester address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 255, cycles bus_valid may stay un-acked before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_ready, or dropped after if_kill.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_kill  in  1  discard the pending/in-flight fetch (pipeline flush_d/int_ack).
- if_ready  out  1  one-cycle fetch completion.
- if_rdata  out  DATA_WIDTH  fetched word, valid with if_ready.
- if_fault  out  1  fetch timed out, valid with if_ready.
- dm_req  in  1  data request; held with stable fields until dm_ready.
- dm_we  in  1  1 = store.
- dm_wstrb  in  DATA_WIDTH/8  byte enables for a store.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_ready  out  1  one-cycle data completion.
- dm_rdata  out  DATA_WIDTH  load data, valid with dm_ready.
- dm_fault  out  1  data access timed out, valid with dm_ready.
- bus_valid  out  1  transfer request to memory.
- bus_we  out  1  write enable.
- bus_wstrb  out  DATA_WIDTH/8  byte enables; 0 on reads.
- bus_addr  out  ADDR_WIDTH  address.
- bus_wdata  out  DATA_WIDTH  write data.
- bus_rdata  in  DATA_WIDTH  read data, valid with bus_ready.
- bus_ready  in  1  memory accepts/completes the transfer this cycle.

Behaviour:
- States: IDLE, FETCH, DATA.
- Reset (async, any state): state IDLE, bus_valid/bus_we/bus_wstrb/bus_addr/bus_wdata = 0, kill flag = 0, timeout counter = 0. All ready/fault outputs are 0 while rst is high.
- Arbitration in IDLE, evaluated each cycle:
  - dm_req -> DATA; latch dm_we, dm_wstrb (forced 0 if dm_we = 0), dm_addr, dm_wdata into the bus registers.
  - Otherwise, if_req & ~if_kill -> FETCH; latch if_addr, bus_we = 0, bus_wstrb = 0.
  - No request: stay IDLE.
  - Fetch cannot starve: MEM holds at most one outstanding access per instruction, and the pipeline stalls on it.
- Bus output timing: all bus outputs are registered. bus_valid = 1 exactly while in FETCH or DATA. Address, control and data are stable for the whole transfer.
- Completion: in FETCH/DATA, bus_ready = 1 completes the transfer that cycle.
  - Owner's ready = 1 combinationally in that cycle; rdata = bus_rdata; fault = 0.
  - Next state is IDLE.
  - Minimum transfer: request in cycle N, bus_valid in N+1, ready in N+1 at the earliest. Next grant earliest at N+2 (one bubble, so a requester that still holds req is never double-served).
- Read data: rdata outputs are 0 whenever ready is 0.
- if_kill:
  - In IDLE: suppresses fetch grant that cycle.
  - In FETCH (including the bus_ready cycle): sets the kill flag. The bus transfer still runs to completion, because memory cannot abort. if_ready is suppressed at completion, and the kill flag clears on return to IDLE.
  - No effect on DATA.
- Timeout (TIMEOUT > 0):
  - Counter clears on entering FETCH/DATA and increments each cycle with bus_valid & ~bus_ready.
  - When the counter equals TIMEOUT and bus_ready = 0: owner's ready = 1, fault = 1, rdata = 0; next state IDLE (bus_valid drops).
  - A killed fetch that times out produces no if_ready/if_fault.
  - bus_ready in the same cycle as the timeout wins: normal completion, no fault.
- Only one of if_ready and dm_ready is ever high in a cycle.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, bus acks 1 cycle after bus_valid with 0xDEADBEEF -> bus_addr = 0x100, bus_we = 0, bus_wstrb = 0; one if_ready pulse with if_rdata = 0xDEADBEEF, if_fault = 0.
- Priority: if_req and dm_req both rise in the same IDLE cycle (dm store, addr 0x2000, wdata 0x12345678, wstrb 0xF) -> store issued first with bus_we = 1, bus_wstrb = 0xF. After dm_ready, one IDLE cycle, then fetch is issued.
- Kill in flight: fetch granted, memory waits 3 cycles, if_kill pulses in wait cycle 2 -> bus_valid held until bus_ready; no if_ready. A new fetch of 0x200 is granted only after returning to IDLE.
- Timeout: TIMEOUT = 4, dm load to 0x3000, bus_ready never asserts -> dm_ready = 1, dm_fault = 1, dm_rdata = 0 in the 5th bus_valid cycle. bus_valid is 0 the next cycle.
- Reset mid-transfer: assert rst during DATA with bus_valid = 1 -> bus_valid = 0 immediately (asynchronously), before the next clock edge. After release, state is IDLE and a pending if_req is granted normally.
- Read with nonzero dm_wstrb = 0x3, dm_we = 0 -> bus_wstrb = 0 on the bus.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory bus between instruction fetch and data access, data first
//   clk, rst                      : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr/if_kill        : fetch request, address, flush of pending/in-flight fetch
//   if_ready/if_rdata/if_fault    : one-cycle fetch completion, word, timeout fault
//   dm_req/dm_we/dm_wstrb/dm_addr/dm_wdata : data request and store fields
//   dm_ready/dm_rdata/dm_fault    : one-cycle data completion, load word, timeout fault
//   bus_valid/bus_we/bus_wstrb/bus_addr/bus_wdata : registered memory request
//   bus_rdata/bus_ready           : memory response
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_kill,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_fault,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic                    dm_ready,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_fault,
    output logic                    bus_valid,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ready
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = TIMEOUT > 0;
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    state_t state, state_nx;
    logic kill_q;
    logic [CW-1:0] cnt;
    logic busy, tmo, fin;
    assign busy = state != IDLE;
    // bus_ready in the timeout cycle wins, so a timeout needs bus_ready low
    assign tmo = TO_EN & busy & ~bus_ready & (cnt == CW'(TIMEOUT));
    assign fin = (busy & bus_ready) | tmo;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = dm_req ? DATA : (if_req & ~if_kill) ? FETCH : IDLE;
        else if (fin) state_nx = IDLE;
    end
    always_comb begin
        if_ready = (state == FETCH) & fin & ~kill_q & ~if_kill;
        if_fault = if_ready & tmo;
        if_rdata = (if_ready & ~tmo) ? bus_rdata : '0;
        dm_ready = (state == DATA) & fin;
        dm_fault = dm_ready & tmo;
        dm_rdata = (dm_ready & ~tmo) ? bus_rdata : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            kill_q    <= 1'b0;
            cnt       <= '0;
        end else begin
            bus_valid <= state_nx != IDLE;
            // a killed fetch still runs to completion; the flag only lives while FETCH continues
            kill_q    <= (state == FETCH) & (state_nx == FETCH) & (kill_q | if_kill);
            cnt       <= busy ? cnt + (bus_ready ? CW'(0) : CW'(1)) : '0;
            if (state == IDLE) begin
                if (dm_req) begin
                    bus_we    <= dm_we;
                    bus_wstrb <= dm_we ? dm_wstrb : '0;
                    bus_addr  <= dm_addr;
                    bus_wdata <= dm_wdata;
                end else if (if_req & ~if_kill) begin
                    bus_we    <= 1'b0;
                    bus_wstrb <= '0;
                    bus_addr  <= if_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: table-driven and scoreboard bench for cpu_mem_arbiter with TIMEOUT = 4
module tb_cpu_mem_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic if_req = 0, if_kill = 0, dm_req = 0, dm_we = 0, bus_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, bus_rdata = 0;
    logic [3:0] dm_wstrb = 0;
    logic if_ready, if_fault, dm_ready, dm_fault, bus_valid, bus_we;
    logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
    logic [3:0] bus_wstrb;
    int errs = 0, checks = 0;

    typedef struct {
        logic dm; logic we; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata;
        int lat; logic ack; logic [31:0] rdata; logic [3:0] exp_wstrb; logic exp_fault;
    } vec_t;
    typedef struct { logic dm; logic [31:0] rdata; logic fault; } sb_t;
    sb_t sb[$];
    sb_t e;
    vec_t vecs[8];

    cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_fault(if_fault),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_fault(dm_fault),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard consumer: every completion pops one expected record
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ready | dm_ready) begin
                chk("one_ready", 64'(if_ready & dm_ready), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b at %0t", if_ready, dm_ready, $time);
                end else begin
                    e = sb.pop_front();
                    chk("owner", 64'(dm_ready), 64'(e.dm));
                    chk("rdata", dm_ready ? dm_rdata : if_rdata, e.rdata);
                    chk("fault", 64'(dm_ready ? dm_fault : if_fault), 64'(e.fault));
                end
            end else begin
                chk("idle_outs", 64'(|if_rdata | |dm_rdata | if_fault | dm_fault), 0);
            end
        end
    end

    task automatic xact(input vec_t v);
        int n;
        cyc();
        if (v.dm) begin
            dm_req = 1; dm_we = v.we; dm_wstrb = v.wstrb; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        sb.push_back('{v.dm, v.exp_fault ? 32'h0 : v.rdata, v.exp_fault});
        n = 0;
        cyc();
        while (!bus_valid && n < 8) begin
            cyc();
            n++;
        end
        chk("grant", 64'(bus_valid), 1);
        chk("bus_addr", bus_addr, v.addr);
        chk("bus_we", 64'(bus_we), 64'(v.dm & v.we));
        chk("bus_wstrb", 64'(bus_wstrb), 64'(v.exp_wstrb));
        if (v.dm & v.we) chk("bus_wdata", bus_wdata, v.wdata);
        for (int c = 0; c < v.lat; c++) cyc();
        chk("valid_hold", 64'(bus_valid), 1);
        chk("addr_hold", bus_addr, v.addr);
        if (v.ack) begin
            bus_ready = 1; bus_rdata = v.rdata;
        end
        cyc();
        bus_ready = 0; bus_rdata = $urandom; if_req = 0; dm_req = 0;
        chk("valid_drop", 64'(bus_valid), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 4'h0, 32'h100,  32'h0,        1, 1, 32'hDEADBEEF, 4'h0, 0};
        vecs[1] = '{1, 1, 4'hF, 32'h2000, 32'h12345678, 0, 1, 32'h00000055, 4'hF, 0};
        vecs[2] = '{1, 0, 4'h0, 32'h3000, 32'h0,        4, 0, 32'hFFFFFFFF, 4'h0, 1};
        vecs[3] = '{1, 0, 4'h3, 32'h44,   32'hAAAA5555, 2, 1, 32'hCAFEF00D, 4'h0, 0};
        vecs[4] = '{0, 0, 4'h0, 32'h104,  32'h0,        3, 1, 32'h13579BDF, 4'h0, 0};
        vecs[5] = '{0, 0, 4'h0, 32'h108,  32'h0,        4, 0, 32'h11111111, 4'h0, 1};
        vecs[6] = '{1, 0, 4'h0, 32'h3004, 32'h0,        4, 1, 32'h0BADCAFE, 4'h0, 0};
        vecs[7] = '{1, 1, 4'h5, 32'h2008, 32'h87654321, 0, 1, 32'h00000000, 4'h5, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus_valid), 0);
        chk("rst_ready", 64'({if_ready, dm_ready, if_fault, dm_fault}), 0);
        chk("rst_addr", bus_addr, 0);
        rst = 0;
        for (int i = 0; i < 8; i++) xact(vecs[i]);

        // data beats fetch when both arrive together; fetch follows after one bubble
        cyc();
        if_req = 1; if_addr = 32'h400;
        dm_req = 1; dm_we = 1; dm_wstrb = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
        sb.push_back('{1, 32'h00000077, 0});
        sb.push_back('{0, 32'h44444444, 0});
        cyc();
        chk("pri_valid", 64'(bus_valid), 1);
        chk("pri_addr", bus_addr, 32'h2000);
        chk("pri_we", 64'(bus_we), 1);
        chk("pri_wstrb", 64'(bus_wstrb), 64'hF);
        bus_ready = 1; bus_rdata = 32'h77;
        cyc();
        bus_ready = 0; dm_req = 0; dm_we = 0;
        chk("pri_bubble", 64'(bus_valid), 0);
        cyc();
        chk("pri_fetch", 64'(bus_valid), 1);
        chk("pri_faddr", bus_addr, 32'h400);
        chk("pri_fwe", 64'(bus_we), 0);
        bus_ready = 1; bus_rdata = 32'h44444444;
        cyc();
        bus_ready = 0; if_req = 0;

        // kill in flight: transfer completes silently, replacement fetch waits for IDLE
        cyc();
        if_req = 1; if_addr = 32'h300;
        cyc();
        chk("kill_grant", bus_addr, 32'h300);
        cyc();
        if_kill = 1; if_addr = 32'h200;
        sb.push_back('{0, 32'h22222222, 0});
        cyc();
        if_kill = 0;
        chk("kill_hold", 64'(bus_valid), 1);
        chk("kill_addr", bus_addr, 32'h300);
        cyc();
        chk("kill_hold2", 64'(bus_valid), 1);
        bus_ready = 1; bus_rdata = 32'hBAD0BAD0;
        cyc();
        bus_ready = 0;
        chk("kill_idle", 64'(bus_valid), 0);
        cyc();
        chk("kill_regrant", 64'(bus_valid), 1);
        chk("kill_newaddr", bus_addr, 32'h200);
        bus_ready = 1; bus_rdata = 32'h22222222;
        cyc();
        bus_ready = 0; if_req = 0;

        // async reset in the middle of a data transfer, pending fetch served afterwards
        cyc();
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        if_req = 1; if_addr = 32'h600;
        cyc();
        chk("mid_valid", 64'(bus_valid), 1);
        rst = 1;
        #1;
        chk("mid_async", 64'(bus_valid), 0);
        chk("mid_ready", 64'({dm_ready, if_ready}), 0);
        dm_req = 0;
        cyc();
        rst = 0;
        sb.push_back('{0, 32'h600DF00D, 0});
        cyc();
        chk("post_rst_grant", 64'(bus_valid), 1);
        chk("post_rst_addr", bus_addr, 32'h600);
        bus_ready = 1; bus_rdata = 32'h600DF00D;
        cyc();
        bus_ready = 0; if_req = 0;
        cyc();
        cyc();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
